// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: inserts stall cycles for in-flight operands, then issues pc_src/flush.
// Optional event counters are compiled in when BRANCH_STATS_EN is defined.
module branch_resolve_unit #(
   parameter int ADDR_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_is_beq,
   input  logic              id_is_bne,
   input  logic [ADDR_W-1:0] id_pc_plus4,
   input  logic [15:0]       id_imm,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              nor_result,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              mem_mem_read,
   input  logic [REG_W-1:0]  mem_rd,
   output logic              stall,
   output logic              pc_src,
   output logic              flush_if_id,
   output logic [ADDR_W-1:0] branch_target
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]       stat_branches,
   output logic [31:0]       stat_taken,
   output logic [31:0]       stat_stall_cycles
`endif
);

   typedef enum logic {S_IDLE, S_STALL} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_cnt;
   logic [1:0]        w_cnt_nxt;
   logic              r_lat_beq;
   logic [ADDR_W-1:0] r_lat_target;

   logic              w_is_br;
   logic              w_dep_ex;
   logic              w_dep_ml;
   logic [1:0]        w_need;
   logic              w_latch;
   logic              w_resolve;
   logic              w_taken;
   logic              w_stall;
   logic [ADDR_W-1:0] w_target;
   logic signed [ADDR_W-1:0] w_offset;
   logic [ADDR_W-1:0] w_target_live;

   // Word offset: sign-extend the 16-bit immediate and scale by 4.
   function automatic logic signed [ADDR_W-1:0] f_br_offset(input logic [15:0] imm);
      logic signed [ADDR_W-1:0] ext;
      ext = {{(ADDR_W-16){imm[15]}}, imm};
      return ext <<< 2;
   endfunction

   function automatic logic f_match(input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] rs,
                                    input logic [REG_W-1:0] rt);
      return (rd == rs) || (rd == rt);
   endfunction

   assign w_offset      = f_br_offset(id_imm);
   assign w_target_live = id_pc_plus4 + $unsigned(w_offset);

   assign w_is_br  = id_valid & (id_is_beq | id_is_bne);
   assign w_dep_ex = ex_reg_write & (ex_rd != '0) & f_match(ex_rd, id_rs, id_rt);
   assign w_dep_ml = mem_mem_read & (mem_rd != '0) & f_match(mem_rd, id_rs, id_rt);

   always_comb begin
      w_need = 2'd0;
      if (w_dep_ex && ex_mem_read) begin
         w_need = 2'd2;
      end else if (w_dep_ex || w_dep_ml) begin
         w_need = 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Opcode and target are captured at detection so later ID changes cannot disturb the stalled branch.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lat_beq    <= 1'b0;
         r_lat_target <= '0;
      end else if (w_latch) begin
         r_lat_beq    <= id_is_beq;
         r_lat_target <= w_target_live;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_resolve   = 1'b0;
      w_taken     = 1'b0;
      w_stall     = 1'b0;
      w_target    = w_target_live;
      case (r_state)
         S_IDLE: begin
            if (w_is_br) begin
               if (w_need == 2'd0) begin
                  w_resolve = 1'b1;
                  w_taken   = id_is_beq ? nor_result : ~nor_result;
               end else begin
                  w_stall     = 1'b1;
                  w_latch     = 1'b1;
                  w_cnt_nxt   = w_need - 2'd1;
                  w_state_nxt = S_STALL;
               end
            end
         end
         S_STALL: begin
            w_target = r_lat_target;
            if (r_cnt != 2'd0) begin
               w_stall   = 1'b1;
               w_cnt_nxt = r_cnt - 2'd1;
            end else begin
               w_resolve   = 1'b1;
               w_taken     = r_lat_beq ? nor_result : ~nor_result;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 2'd0;
         end
      endcase
   end

   // Every output reads as zero while reset is held.
   assign stall         = rst ? 1'b0 : w_stall;
   assign pc_src        = rst ? 1'b0 : w_taken;
   assign flush_if_id   = rst ? 1'b0 : w_taken;
   assign branch_target = rst ? '0   : w_target;

`ifdef BRANCH_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_taken;
   logic [31:0] r_stat_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_branches <= 32'd0;
         r_stat_taken    <= 32'd0;
         r_stat_stall    <= 32'd0;
      end else begin
         if (w_resolve) r_stat_branches <= r_stat_branches + 32'd1;
         if (w_resolve && w_taken) r_stat_taken <= r_stat_taken + 32'd1;
         if (w_stall) r_stat_stall <= r_stat_stall + 32'd1;
      end
   end

   assign stat_branches     = r_stat_branches;
   assign stat_taken        = r_stat_taken;
   assign stat_stall_cycles = r_stat_stall;
`endif

endmodule
